regfile_dump_tx: RTL and testbench
==================================

Name: regfile_dump_tx

Overview:
- Debug reader for the CPU register file.
- On a start request it walks register addresses 0..NREGS-1 through one register-file read port, sampling each value in turn.
- Each value is serialized out of a single UART-style TX pin: 8N1-like framing, WIDTH data bits, LSB first.
- Sits beside the register file in the top level and drives that file's ra/rd read pair, so board-level tools can capture register state without the debug taps.

Parameters:
- WIDTH, 8, register data width; also the number of data bits per frame.
- NREGS, 8, number of registers dumped (addresses 0..NREGS-1); 1 ≤ NREGS ≤ 32.
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); must be ≥ 2.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  request a dump; sampled only in IDLE.
- rd  in  WIDTH  read data from register-file read port (combinational from ra).
- ra  out  5  read address to register-file read port, registered.
- tx  out  1  serial line, idle high, registered.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse after the last stop bit of the last register.

Behaviour:
- Reset: rst low at a posedge forces the following in the next cycle, regardless of current state:
  - state=IDLE, tx=1, busy=0, done=0, ra=0;
  - idx=0, bit counter=0, baud counter=0.
  - Reset mid-frame truncates the frame; tx returns high on that edge.
- States: IDLE, ADDR, LOAD, START, DATA, STOP, DONE.
- IDLE: tx=1, busy=0. start=1 → ADDR, idx=0, busy=1. start=0 → stay.
- ADDR (1 cycle): ra<=idx → LOAD.
- LOAD (1 cycle): shift<=rd (value at address idx) → START.
  - rd is sampled exactly once per register, in LOAD; later writes to that register do not alter its frame.
- START: tx=0 for CLKS_PER_BIT cycles → DATA, bit=0.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles, then shift right by 1 and bit++.
  - After bit WIDTH-1 completes → STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then:
  - if idx==NREGS-1 → DONE;
  - else idx++ → ADDR.
- DONE (1 cycle): done=1, busy remains 1; next cycle → IDLE, busy=0.
- Baud counter: counts 0..CLKS_PER_BIT-1 and emits a tick on the last count. It is cleared on entry to START, so every bit is exactly CLKS_PER_BIT cycles wide with no jitter.
- tx is registered: tx changes on the same edge as the state transition into START/DATA/STOP.
- Per-register time: 2 + (WIDTH+2)·CLKS_PER_BIT cycles. Total dump time: NREGS × that value, plus 1 cycle for DONE.
- Simultaneous events:
  - start while busy: ignored (no queuing).
  - start high in the DONE cycle: ignored.
  - start held high continuously: a new dump begins on the first IDLE cycle.
- Widths:
  - idx is 5 bits; ra = idx zero-extended.
  - Bit counter is $clog2(WIDTH+1) bits.
  - Baud counter is $clog2(CLKS_PER_BIT) bits.

Decomposition:
- Package regfile_dbg_pkg holds:
  - state_t enum (IDLE, ADDR, LOAD, START, DATA, STOP, DONE);
  - localparam ADDR_W=5;
  - TX_IDLE=1'b1, TX_START=1'b0.
- One sub-module, baud_tick_gen. Parameter CLKS_PER_BIT. Inputs clk, rst, clr. Output tick. tick is high for 1 cycle every CLKS_PER_BIT cycles after clr.
- The FSM, shift register and idx counter stay in regfile_dump_tx.

Test Plan (WIDTH=8, NREGS=8, CLKS_PER_BIT=4; register-file model preloaded r0=00, r1=11, r2=22 … r7=77):
- Reset: hold rst=0 for 3 cycles with start=1 → tx=1, busy=0, done=0, ra=0 throughout; no frame starts while rst=0.
- Full dump: pulse start for 1 cycle →
  - busy rises next cycle;
  - ra steps 0..7;
  - decoded frames are 00,11,22,33,44,55,66,77, each with start bit 0 and stop bit 1, bit width 4 cycles;
  - done pulses once, exactly 8·(2+40)+1 = 337 cycles after busy rises; busy falls the cycle after done.
- LSB-first check: r1=A5 → after r0's frame, tx bit sequence 0,1,0,1,0,0,1,0,1,1 (start, data LSB→MSB, stop).
- Write during dump: while r0's frame is being sent, write r3=C3 → frame 3 shows C3. A write to r0 at the same point does not change r0's frame.
- start while busy: pulse start mid-dump → still exactly 8 frames and one done pulse; no restart.
- Reset mid-frame: drive rst=0 during DATA of r2 → next cycle tx=1, busy=0, state IDLE. A subsequent start produces a complete dump beginning at r0.

Source files
------------

// File: rtl/regfile_dump_tx_pkg.sv
// Shared types and constants for the register-file debug dumper.
package regfile_dbg_pkg;

    localparam int   ADDR_W   = 5;
    localparam logic TX_IDLE  = 1'b1;
    localparam logic TX_START = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5,
        DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/regfile_dump_tx_if.sv
// Bundle of the dumper's request, register-file read pair and serial output.
interface regfile_dump_tx_if #(
    parameter int WIDTH = 8
);
    import regfile_dbg_pkg::*;

    logic              start;
    logic [WIDTH-1:0]  rd;
    logic [ADDR_W-1:0] ra;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (input start, input rd, output ra, output tx, output busy, output done);
    modport slave  (output start, output rd, input ra, input tx, input busy, input done);

endinterface

// File: rtl/regfile_dump_tx_baud_tick_gen.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT cycles, restartable by clr.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int             CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             tick_r;

    // Next count: restart on clr, wrap after the last count of a bit.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = '0;
        end else if (cnt_r == LAST) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Counter and registered tick, aligned with the cycle holding the last count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= (cnt_nxt_s == LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/regfile_dump_tx.sv
// Walks the register file read port and serializes each value as an 8N1-style frame.
module regfile_dump_tx #(
    parameter int WIDTH        = 8,
    parameter int NREGS        = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic               clk,
    input  logic               rst,
    regfile_dump_tx_if.master  bus
);
    import regfile_dbg_pkg::*;

    localparam int                BIT_W    = $clog2(WIDTH + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WIDTH - 1);

    state_t            state_r;
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W-1:0] ra_r;
    logic [BIT_W-1:0]  bit_r;
    logic [WIDTH-1:0]  shift_r;
    logic [WIDTH-1:0]  shift_nxt_s;
    logic              tx_r;
    logic              busy_r;
    logic              done_r;
    logic              tick_s;
    logic              clr_s;

    // Restarting the timer in LOAD makes the start bit begin on a fresh count.
    assign clr_s       = (state_r == LOAD);
    assign shift_nxt_s = shift_r >> 1;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .tick (tick_s)
    );

    // Dump sequencer; tx, ra, busy and done are all set on the state-changing edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            idx_r   <= '0;
            ra_r    <= '0;
            bit_r   <= '0;
            shift_r <= '0;
            tx_r    <= TX_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    tx_r   <= TX_IDLE;
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r <= ADDR;
                        idx_r   <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ADDR: begin
                    ra_r    <= idx_r;
                    state_r <= LOAD;
                end
                LOAD: begin
                    shift_r <= bus.rd;
                    tx_r    <= TX_START;
                    state_r <= START;
                end
                START: begin
                    if (tick_s) begin
                        tx_r    <= shift_r[0];
                        bit_r   <= '0;
                        state_r <= DATA;
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        shift_r <= shift_nxt_s;
                        bit_r   <= bit_r + BIT_W'(1);
                        if (bit_r == LAST_BIT) begin
                            tx_r    <= TX_IDLE;
                            state_r <= STOP;
                        end else begin
                            tx_r    <= shift_nxt_s[0];
                        end
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        if (idx_r == LAST_IDX) begin
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            idx_r   <= idx_r + ADDR_W'(1);
                            state_r <= ADDR;
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    tx_r    <= TX_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ra   = ra_r;
    assign bus.tx   = tx_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Scoreboard bench for regfile_dump_tx: decodes the serial line and checks frames, ra, busy and done.
module tb_regfile_dump_tx;

    localparam int CPB = 4;

    typedef struct {
        logic [4:0] idx;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] regs [0:7];
    exp_t       exp_q [$];
    logic [9:0] obs_seq [0:7];

    int checks;
    int failures;
    int busy_cnt;
    int done_cnt;
    int done_at;
    int frames_seen;
    int aborts;

    regfile_dump_tx_if #(.WIDTH(8)) bus ();

    assign bus.rd = regs[bus.ra[2:0]];

    regfile_dump_tx #(
        .WIDTH        (8),
        .NREGS        (8),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    // Samples every cycle of each bit; seq[i] is the i-th bit on the line.
    task automatic decoder_loop();
        logic [9:0] seq;
        logic [4:0] ra_at;
        bit         glitch;
        bit         aborted;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && bus.tx === 1'b0) begin
                ra_at   = bus.ra;
                glitch  = 1'b0;
                aborted = 1'b0;
                seq     = '0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int s = 0; s < CPB; s++) begin
                        if (!(b == 0 && s == 0)) @(negedge clk);
                        if (rst !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (s == 0) seq[b] = bus.tx;
                        else if (bus.tx !== seq[b]) glitch = 1'b1;
                    end
                end
                if (aborted) begin
                    aborts++;
                end else begin
                    frames_seen++;
                    obs_seq[ra_at[2:0]] = seq;
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_frame", 32'(seq), 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("frame_bits", 32'(seq), 32'(frame_of(e.data)));
                        check_eq("frame_ra", 32'(ra_at), 32'(e.idx));
                        check_eq("bit_width_stable", 32'(glitch), 32'h0);
                    end
                end
            end
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_at = busy_cnt;
            end
        end
    endtask

    task automatic push_defaults();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{idx: 5'(i), data: 8'(i * 17)});
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == base) check_eq("done_timeout", 32'h0, 32'h1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_dump(input string tag, input int b0, input int d0, input int f0);
        check_eq({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        check_eq({tag, "_done_cycle"}, 32'(done_at - b0), 32'd337);
        check_eq({tag, "_busy_cycles"}, 32'(busy_cnt - b0), 32'd337);
        check_eq({tag, "_frames"}, 32'(frames_seen - f0), 32'd8);
        check_eq({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_idle_busy"}, 32'(bus.busy), 32'h0);
    endtask

    initial begin
        int b0, d0, f0, a0, n;
        checks = 0; failures = 0;
        busy_cnt = 0; done_cnt = 0; done_at = 0; frames_seen = 0; aborts = 0;
        for (int i = 0; i < 8; i++) regs[i] = 8'(i * 17);
        rst = 1'b0;
        bus.start = 1'b1;
        fork
            decoder_loop();
            monitor_loop();
        join_none

        // Reset held with start high
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("rst_tx", 32'(bus.tx), 32'h1);
            check_eq("rst_busy", 32'(bus.busy), 32'h0);
            check_eq("rst_done", 32'(bus.done), 32'h0);
            check_eq("rst_ra", 32'(bus.ra), 32'h0);
        end
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_no_frame", 32'(frames_seen + aborts), 32'h0);

        // Full dump of default contents
        b0 = busy_cnt; d0 = done_cnt; f0 = frames_seen;
        push_defaults();
        pulse_start();
        check_eq("busy_rise", 32'(bus.busy), 32'h1);
        wait_done(1000);
        check_dump("full", b0, d0, f0);

        // LSB-first ordering with r1=A5
        regs[1] = 8'hA5;
        b0 = busy_cnt; d0 = done_cnt; f0 = frames_seen;
        for (int i = 0; i < 8; i++) exp_q.push_back('{idx: 5'(i), data: regs[i]});
        pulse_start();
        wait_done(1000);
        check_dump("lsb", b0, d0, f0);
        check_eq("lsb_seq_r1", 32'(obs_seq[1]), 32'h34A);
        regs[1] = 8'h11;

        // Writes during r0's frame, plus a start request while busy
        b0 = busy_cnt; d0 = done_cnt; f0 = frames_seen;
        push_defaults();
        exp_q[3].data = 8'hC3;
        pulse_start();
        repeat (12) @(negedge clk);
        regs[3] = 8'hC3;
        regs[0] = 8'hFF;
        repeat (140) @(negedge clk);
        pulse_start();
        wait_done(1000);
        check_dump("wr_busy", b0, d0, f0);
        for (int i = 0; i < 8; i++) regs[i] = 8'(i * 17);

        // Reset in the middle of r2's data bits
        a0 = aborts;
        push_defaults();
        pulse_start();
        n = 0;
        while (bus.ra !== 5'd2 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_r2", 32'(bus.ra), 32'h2);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_tx", 32'(bus.tx), 32'h1);
        check_eq("midrst_busy", 32'(bus.busy), 32'h0);
        check_eq("midrst_ra", 32'(bus.ra), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        repeat (6) @(negedge clk);
        check_eq("midrst_stays_idle", 32'({bus.busy, bus.tx}), 32'h1);
        check_eq("midrst_aborted", 32'(aborts - a0), 32'h1);

        b0 = busy_cnt; d0 = done_cnt; f0 = frames_seen;
        push_defaults();
        pulse_start();
        wait_done(1000);
        check_dump("after_rst", b0, d0, f0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
